// File: rtl/spi_flash_reader.sv
// SPI flash READ (0x03) sequencer driving a byte-wide SPI master's two-register bus.
// Sends command plus 24-bit address, then streams N received bytes out with valid/ready.
module spi_flash_reader #(
    parameter int unsigned LEN_W    = 8,
    parameter logic [7:0]  CMD_READ = 8'h03
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [23:0]      i_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_valid,
    output logic [7:0]       o_data,
    input  logic             i_ready,
    output logic             o_spi_addr,
    output logic             o_spi_cs,
    output logic             o_spi_we,
    output logic [7:0]       o_spi_dat,
    input  logic [7:0]       i_spi_dat
);

    typedef enum logic [2:0] {
        StIdle, StSel, StTxWr, StTxWait, StRxRd, StOut, StDesel, StDone
    } state_t;

    state_t           r_state, w_state_d;
    logic [23:0]      r_addr, w_addr_d;
    logic [LEN_W-1:0] r_len, w_len_d;
    logic [LEN_W-1:0] r_count, w_count_d, w_count_inc;
    logic [1:0]       r_phase, w_phase_d;
    logic             r_data_ph, w_data_ph_d;
    logic             r_valid, w_valid_d;
    logic [7:0]       r_data, w_data_d;
    logic             r_busy, r_done;
    logic             r_spi_addr, r_spi_cs, r_spi_we;
    logic [7:0]       r_spi_dat;
    logic             w_spi_addr, w_spi_cs, w_spi_we;
    logic [7:0]       w_spi_dat, w_tx_byte;

    assign w_count_inc = r_count + LEN_W'(1);

    always_comb begin
        w_state_d   = r_state;
        w_addr_d    = r_addr;
        w_len_d     = r_len;
        w_count_d   = r_count;
        w_phase_d   = r_phase;
        w_data_ph_d = r_data_ph;
        w_valid_d   = r_valid;
        w_data_d    = r_data;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_addr_d    = i_addr;
                    w_len_d     = i_len;
                    w_count_d   = '0;
                    w_phase_d   = 2'd0;
                    w_data_ph_d = 1'b0;
                    w_state_d   = (i_len == '0) ? StDone : StSel;
                end
            end
            StSel:  w_state_d = StTxWr;
            StTxWr: w_state_d = StTxWait;
            StTxWait: begin
                if (!i_spi_dat[7]) begin
                    if (r_data_ph) begin
                        w_state_d = StRxRd;
                    end else begin
                        if (r_phase == 2'd3) begin
                            w_data_ph_d = 1'b1;
                        end else begin
                            w_phase_d = r_phase + 2'd1;
                        end
                        w_state_d = StTxWr;
                    end
                end
            end
            StRxRd: begin
                w_data_d  = i_spi_dat;
                w_valid_d = 1'b1;
                w_state_d = StOut;
            end
            StOut: begin
                // Full backpressure: the next SPI byte starts only after this handshake.
                if (i_ready) begin
                    w_valid_d = 1'b0;
                    w_count_d = w_count_inc;
                    w_state_d = (w_count_inc == r_len) ? StDesel : StTxWr;
                end
            end
            StDesel: w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_tx_byte = 8'h00;
        if (!w_data_ph_d) begin
            unique case (w_phase_d)
                2'd0: w_tx_byte = CMD_READ;
                2'd1: w_tx_byte = w_addr_d[23:16];
                2'd2: w_tx_byte = w_addr_d[15:8];
                2'd3: w_tx_byte = w_addr_d[7:0];
                default: w_tx_byte = 8'h00;
            endcase
        end
    end

    // Bus outputs are decoded from the next state so they line up with the state that owns them.
    always_comb begin
        w_spi_addr = 1'b0;
        w_spi_cs   = 1'b0;
        w_spi_we   = 1'b0;
        w_spi_dat  = 8'h00;
        unique case (w_state_d)
            StSel: begin
                w_spi_cs  = 1'b1;
                w_spi_we  = 1'b1;
                w_spi_dat = 8'h01;
            end
            StTxWr: begin
                w_spi_cs   = 1'b1;
                w_spi_we   = 1'b1;
                w_spi_addr = 1'b1;
                w_spi_dat  = w_tx_byte;
            end
            StTxWait: w_spi_cs = 1'b1;
            StRxRd: begin
                w_spi_cs   = 1'b1;
                w_spi_addr = 1'b1;
            end
            StDesel: begin
                w_spi_cs = 1'b1;
                w_spi_we = 1'b1;
            end
            default: begin
                w_spi_cs = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_phase    <= 2'd0;
            r_data_ph  <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_spi_addr <= 1'b0;
            r_spi_cs   <= 1'b0;
            r_spi_we   <= 1'b0;
            r_spi_dat  <= 8'h00;
        end else begin
            r_state    <= w_state_d;
            r_addr     <= w_addr_d;
            r_len      <= w_len_d;
            r_count    <= w_count_d;
            r_phase    <= w_phase_d;
            r_data_ph  <= w_data_ph_d;
            r_valid    <= w_valid_d;
            r_data     <= w_data_d;
            r_busy     <= (w_state_d != StIdle);
            r_done     <= (w_state_d == StDone);
            r_spi_addr <= w_spi_addr;
            r_spi_cs   <= w_spi_cs;
            r_spi_we   <= w_spi_we;
            r_spi_dat  <= w_spi_dat;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_spi_addr = r_spi_addr;
    assign o_spi_cs   = r_spi_cs;
    assign o_spi_we   = r_spi_we;
    assign o_spi_dat  = r_spi_dat;

endmodule
